// File: rtl/apb_timer_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets, bit positions, CKS codes.
package apb_timer_pkg;

    localparam int CH_STRIDE = 8;

    localparam logic [2:0] OFF_TDR  = 3'd0;
    localparam logic [2:0] OFF_TCR  = 3'd1;
    localparam logic [2:0] OFF_TSR  = 3'd2;
    localparam logic [2:0] OFF_TIER = 3'd3;
    localparam logic [2:0] OFF_TCNT = 3'd4;

    localparam int TCR_LOAD = 7;
    localparam int TCR_DIR  = 5;
    localparam int TCR_EN   = 4;
    localparam int TCR_CKS  = 0;
    localparam logic [7:0] TCR_MASK = 8'hB3;

    localparam int TIER_OVF_IE = 0;
    localparam int TIER_UDF_IE = 1;
    localparam int TIER_ARE    = 2;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    // A channel ticks when the low CKS+1 prescaler bits are all ones.
    function automatic logic tick_hit(input logic [3:0] pre, input logic [1:0] cks);
        logic hit;
        case (cks)
            CKS_DIV2:  hit = pre[0];
            CKS_DIV4:  hit = &pre[1:0];
            CKS_DIV8:  hit = &pre[2:0];
            default:   hit = &pre;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TDR/TCR/TIER/TSR registers, up/down counter, flags and interrupt.
module timer_channel
    import apb_timer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              wr_tdr,
    input  logic              wr_tcr,
    input  logic              wr_tsr,
    input  logic              wr_tier,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pre,
    input  logic              run,
    output logic [DATA_W-1:0] tdr_rd,
    output logic [DATA_W-1:0] tcr_rd,
    output logic [DATA_W-1:0] tsr_rd,
    output logic [DATA_W-1:0] tier_rd,
    output logic [DATA_W-1:0] cnt_rd,
    output logic              irq
);

    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] tdr;
    logic [7:0]        tcr;
    logic [2:0]        tier;
    logic [1:0]        tsr;
    logic [DATA_W-1:0] cnt;

    logic              tick;
    logic              set_ovf;
    logic              set_udf;
    logic [DATA_W-1:0] cnt_n;
    logic [1:0]        tsr_n;

    assign tick = run & tcr[TCR_EN] & ~tcr[TCR_LOAD] & tick_hit(pre, tcr[TCR_CKS +: 2]);

    // Everything here reads the current register values, so a same-cycle
    // TCR/TDR write only takes effect from the following cycle.
    always_comb begin
        cnt_n   = cnt;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (tcr[TCR_LOAD]) begin
            cnt_n = tdr;
        end else if (tick) begin
            if (!tcr[TCR_DIR]) begin
                if (cnt == CNT_MAX) begin
                    set_ovf = 1'b1;
                    cnt_n   = tier[TIER_ARE] ? tdr : '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    set_udf = 1'b1;
                    cnt_n   = tier[TIER_ARE] ? tdr : CNT_MAX;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
        end
    end

    // Hardware set is applied after the W1C clear so it wins a collision.
    always_comb begin
        tsr_n = tsr;
        if (wr_tsr) tsr_n = tsr_n & ~pwdata[1:0];
        if (set_ovf) tsr_n[TSR_OVF] = 1'b1;
        if (set_udf) tsr_n[TSR_UDF] = 1'b1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= '0;
            tcr  <= '0;
            tier <= '0;
            tsr  <= '0;
            cnt  <= '0;
        end else begin
            if (wr_tdr)  tdr  <= pwdata;
            if (wr_tcr)  tcr  <= pwdata[7:0] & TCR_MASK;
            if (wr_tier) tier <= pwdata[2:0];
            tsr <= tsr_n;
            cnt <= cnt_n;
        end
    end

    assign tdr_rd  = tdr;
    assign tcr_rd  = DATA_W'(tcr);
    assign tsr_rd  = DATA_W'(tsr);
    assign tier_rd = DATA_W'(tier);
    assign cnt_rd  = cnt;

    assign irq = (tsr[TSR_OVF] & tier[TIER_OVF_IE]) | (tsr[TSR_UDF] & tier[TIER_UDF_IE]);

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer top: APB decode, error response, read mux and shared prescaler.
// Optional APB_TIMER_DBG_HALT_EN adds a dbg_halt input that freezes prescaler and ticks.
module apb_timer_mc
    import apb_timer_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_TIMER_DBG_HALT_EN
    input  logic              dbg_halt,
`endif
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any
);

    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(N_CH * CH_STRIDE);

    logic [2:0]        offset;
    logic [ADDR_W-4:0] ch_idx;
    logic              access;
    logic              bad;
    logic              wr_ok;
    logic              run;
    logic [3:0]        pre;
    logic [DATA_W-1:0] rd_mux;

    logic [DATA_W-1:0] tdr_rd  [N_CH];
    logic [DATA_W-1:0] tcr_rd  [N_CH];
    logic [DATA_W-1:0] tsr_rd  [N_CH];
    logic [DATA_W-1:0] tier_rd [N_CH];
    logic [DATA_W-1:0] cnt_rd  [N_CH];

    assign offset = paddr[2:0];
    assign ch_idx = paddr[ADDR_W-1:3];
    assign access = psel & penable;
    assign bad    = (offset > OFF_TCNT) | (paddr >= ADDR_LIM) | (pwrite & (offset == OFF_TCNT));
    assign wr_ok  = access & pwrite & ~bad;

    assign pready  = access;
    assign pslverr = access & bad;

`ifdef APB_TIMER_DBG_HALT_EN
    assign run = ~dbg_halt;
`else
    assign run = 1'b1;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pre <= '0;
        end else if (run) begin
            pre <= pre + 4'd1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic wr_ch;
        assign wr_ch = wr_ok & (ch_idx == (ADDR_W-3)'(c));

        timer_channel #(.DATA_W(DATA_W)) u_ch (
            .pclk    (pclk),
            .presetn (presetn),
            .wr_tdr  (wr_ch & (offset == OFF_TDR)),
            .wr_tcr  (wr_ch & (offset == OFF_TCR)),
            .wr_tsr  (wr_ch & (offset == OFF_TSR)),
            .wr_tier (wr_ch & (offset == OFF_TIER)),
            .pwdata  (pwdata),
            .pre     (pre),
            .run     (run),
            .tdr_rd  (tdr_rd[c]),
            .tcr_rd  (tcr_rd[c]),
            .tsr_rd  (tsr_rd[c]),
            .tier_rd (tier_rd[c]),
            .cnt_rd  (cnt_rd[c]),
            .irq     (irq[c])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == (ADDR_W-3)'(c)) begin
                case (offset)
                    OFF_TDR:  rd_mux = tdr_rd[c];
                    OFF_TCR:  rd_mux = tcr_rd[c];
                    OFF_TSR:  rd_mux = tsr_rd[c];
                    OFF_TIER: rd_mux = tier_rd[c];
                    OFF_TCNT: rd_mux = cnt_rd[c];
                    default:  rd_mux = '0;
                endcase
            end
        end
    end

    assign prdata  = (access & ~bad) ? rd_mux : '0;
    assign irq_any = |irq;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed bench for apb_timer_mc: register table, counting sequences, W1C race, halt, reset.
module tb_apb_timer_mc;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [1:0] irq;
    logic       irq_any;
`ifdef APB_TIMER_DBG_HALT_EN
    logic       dbg_halt = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] tb_pre;

    always #5 pclk = ~pclk;

    apb_timer_mc #(.N_CH(2), .DATA_W(8), .ADDR_W(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
`ifdef APB_TIMER_DBG_HALT_EN
        .dbg_halt(dbg_halt),
`endif
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq),
        .irq_any (irq_any)
    );

    // Reference free-running prescaler, used only to place accesses on tick cycles.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) tb_pre <= '0;
`ifdef APB_TIMER_DBG_HALT_EN
        else if (!dbg_halt) tb_pre <= tb_pre + 4'd1;
`else
        else tb_pre <= tb_pre + 4'd1;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] w, output logic e);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = w;
        @(negedge pclk);
        penable = 1'b1;
        #1 e = pslverr;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d, output logic e);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        #1 d = prdata; e = pslverr;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    // Write whose setup cycle sees prescaler value ph, so the access cycle sees ph+1.
    task automatic apb_wr_at(input logic [7:0] a, input logic [7:0] w, input logic [3:0] ph);
        int k;
        k = 0;
        @(negedge pclk);
        while (tb_pre != ph && k < 40) begin
            @(negedge pclk);
            k++;
        end
        chk("align_wait", 32'(k < 40), 32'd1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = w;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] seq0 [3];
    logic [7:0] seq1 [4];

    initial begin
        logic [7:0] v;
        logic [7:0] prev;
        logic       e;
        int         k;

        seq0 = '{8'hFE, 8'hFF, 8'h00};
        seq1 = '{8'h02, 8'h01, 8'h00, 8'h03};

        // {wr, addr, wdata, expected rdata, expected pslverr}
        tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h01, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h02, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h03, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h04, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h0C, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h00, 8'hA5, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0});
        tbl.push_back('{1'b1, 8'h08, 8'h3C, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h08, 8'h00, 8'h3C, 1'b0});
        tbl.push_back('{1'b1, 8'h03, 8'hFF, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h03, 8'h00, 8'h07, 1'b0});
        tbl.push_back('{1'b1, 8'h0B, 8'h0A, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h0B, 8'h00, 8'h02, 1'b0});
        tbl.push_back('{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0});
        tbl.push_back('{1'b0, 8'h04, 8'h00, 8'hA5, 1'b0});
        tbl.push_back('{1'b1, 8'h01, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h09, 8'h4C, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h09, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h02, 8'hFF, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h02, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h05, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 8'h07, 8'h11, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h07, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h10, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 8'h10, 8'h99, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 8'h04, 8'h55, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h04, 8'h00, 8'hA5, 1'b0});
        tbl.push_back('{1'b1, 8'h0D, 8'h12, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h08, 8'h00, 8'h3C, 1'b0});
        tbl.push_back('{1'b1, 8'h03, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h0B, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h03, 8'h00, 8'h00, 1'b0});

        repeat (3) @(posedge pclk);
        #1;
        chk("rst_prdata", 32'(prdata), 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_irq", 32'({irq_any, irq}), 32'h0);
        @(negedge pclk);
        presetn = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                apb_wr(tbl[i].addr, tbl[i].data, e);
                chk($sformatf("tbl%0d_wr_err", i), 32'(e), 32'(tbl[i].err));
            end else begin
                apb_rd(tbl[i].addr, v, e);
                chk($sformatf("tbl%0d_rd_err", i), 32'(e), 32'(tbl[i].err));
                chk($sformatf("tbl%0d_rd_data", i), 32'(v), 32'(tbl[i].exp));
            end
        end

        // ch0 up-count through the wrap at CKS=0 with OVF interrupt
        apb_wr(8'h00, 8'hFD, e);
        apb_wr(8'h03, 8'h01, e);
        apb_wr(8'h01, 8'h80, e);
        apb_wr(8'h01, 8'h10, e);
        prev = 8'hFD;
        foreach (seq0[i]) begin
            k = 0;
            do begin
                apb_rd(8'h04, v, e);
                k++;
            end while (v == prev && k < 8);
            chk($sformatf("ch0_tcnt%0d", i), 32'(v), 32'(seq0[i]));
            if (i > 0) chk($sformatf("ch0_spacing%0d", i), 32'(k), 32'd1);
            prev = v;
        end
        apb_rd(8'h02, v, e);
        chk("ch0_ovf", 32'(v), 32'h01);
        chk("ch0_irq", 32'({irq_any, irq}), 32'b101);
        apb_wr(8'h02, 8'h01, e);
        chk("ch0_irq_clr", 32'({irq_any, irq}), 32'b000);
        apb_rd(8'h02, v, e);
        chk("ch0_ovf_clr", 32'(v), 32'h00);
        apb_wr(8'h01, 8'h00, e);
        apb_wr(8'h03, 8'h00, e);

        // ch1 down-count with auto-reload at CKS=3, UDF interrupt masked
        apb_wr(8'h08, 8'h03, e);
        apb_wr(8'h0B, 8'h04, e);
        apb_wr(8'h09, 8'h80, e);
        apb_wr(8'h09, 8'h33, e);
        prev = 8'h03;
        foreach (seq1[i]) begin
            k = 0;
            do begin
                apb_rd(8'h0C, v, e);
                k++;
            end while (v == prev && k < 12);
            chk($sformatf("ch1_tcnt%0d", i), 32'(v), 32'(seq1[i]));
            if (i > 0) chk($sformatf("ch1_spacing%0d", i), 32'(k), 32'd8);
            prev = v;
        end
        apb_rd(8'h0A, v, e);
        chk("ch1_udf", 32'(v), 32'h02);
        chk("ch1_irq_masked", 32'({irq_any, irq}), 32'b000);

`ifdef APB_TIMER_DBG_HALT_EN
        k = 0;
        do begin
            apb_rd(8'h0C, v, e);
            k++;
        end while (v == 8'h03 && k < 12);
        chk("halt_pre_cnt", 32'(v), 32'h02);
        dbg_halt = 1'b1;
        for (int i = 0; i < 25; i++) begin
            apb_rd(8'h0C, v, e);
            chk($sformatf("halt_cnt%0d", i), 32'(v), 32'h02);
        end
        apb_rd(8'h08, v, e);
        chk("halt_tdr_rd", 32'(v), 32'h03);
        dbg_halt = 1'b0;
        k = 0;
        do begin
            apb_rd(8'h0C, v, e);
            k++;
        end while (v == 8'h02 && k < 12);
        chk("halt_resume_cnt", 32'(v), 32'h01);
`endif

        // ch0 reloads 0xFF on every CKS=3 tick, so each tick is an overflow
        apb_wr(8'h00, 8'hFF, e);
        apb_wr(8'h03, 8'h05, e);
        apb_wr(8'h01, 8'h80, e);
        apb_wr(8'h01, 8'h13, e);
        k = 0;
        do begin
            apb_rd(8'h02, v, e);
            k++;
        end while (v != 8'h01 && k < 20);
        chk("race_ovf_set", 32'(v), 32'h01);
        apb_wr_at(8'h02, 8'h01, 4'h3);
        apb_rd(8'h02, v, e);
        chk("race_clr_quiet", 32'(v), 32'h00);
        apb_wr_at(8'h02, 8'h01, 4'hE);
        apb_rd(8'h02, v, e);
        chk("race_set_wins", 32'(v), 32'h01);
        chk("race_irq", 32'(irq[0]), 32'h1);

        // asynchronous reset mid-count
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("arst_irq", 32'({irq_any, irq}), 32'b000);
        @(negedge pclk);
        presetn = 1'b1;
        apb_rd(8'h04, v, e);
        chk("arst_tcnt", 32'(v), 32'h00);
        apb_rd(8'h01, v, e);
        chk("arst_tcr", 32'(v), 32'h00);
        apb_rd(8'h02, v, e);
        chk("arst_tsr", 32'(v), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
